// File: rtl/pattern_response_misr.sv
// pattern_response_misr
//   Capture stage that compacts a window of pattern output vectors into a
//   multiple-input signature register and offers the final signature to the
//   harness over a valid/ack handshake.
//
//   Optional feature macro: PATTERN_MISR_GOLDEN_CMP_EN
//     When defined, the block adds golden_i and pass_o. On the edge that
//     enters DONE, pass_o registers whether the final signature equals golden_i.
//
//   Ports
//     blif_clk_net    in   clock, rising edge
//     blif_reset_net  in   asynchronous reset, active-high
//     start_i         in   request a new window (level-sampled in IDLE)
//     win_len_i       in   window length, latched on an accepted start
//     resp_valid_i    in   resp_i is valid this cycle
//     resp_i          in   pattern output vector
//     sig_ack_i       in   harness has consumed the signature
//     busy_o          out  high in RUN
//     sig_valid_o     out  high in DONE
//     sig_o           out  signature register
//     vec_cnt_o       out  vectors absorbed in the current window
//     drop_o          out  sticky: a valid vector arrived outside RUN
//     golden_i        in   expected signature      (feature only)
//     pass_o          out  final signature matched (feature only)
module pattern_response_misr #(
  parameter int unsigned      RESP_W = 13,
  parameter int unsigned      SIG_W  = 16,
  parameter int unsigned      CNT_W  = 8,
  parameter logic [SIG_W-1:0] POLY   = 16'h8016,
  parameter logic [SIG_W-1:0] SEED   = 16'h0000
) (
  input  logic              blif_clk_net,
  input  logic              blif_reset_net,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  win_len_i,
  input  logic              resp_valid_i,
  input  logic [RESP_W-1:0] resp_i,
  input  logic              sig_ack_i,
`ifdef PATTERN_MISR_GOLDEN_CMP_EN
  input  logic [SIG_W-1:0]  golden_i,
  output logic              pass_o,
`endif
  output logic              busy_o,
  output logic              sig_valid_o,
  output logic [SIG_W-1:0]  sig_o,
  output logic [CNT_W-1:0]  vec_cnt_o,
  output logic              drop_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [SIG_W-1:0]   sig_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   len_d;
  logic               drop_d;
`ifdef PATTERN_MISR_GOLDEN_CMP_EN
  logic               pass_d;
`endif

  // One MISR step: shift left, fold the MSB back through the taps, absorb the vector.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [RESP_W-1:0] r);
    logic [SIG_W-1:0] fb;
    fb = s[SIG_W-1] ? POLY : '0;
    return {s[SIG_W-2:0], 1'b0} ^ fb ^ SIG_W'(r);
  endfunction

  // State register.
  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Next-state and next datapath values.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_o;
    cnt_d   = vec_cnt_o;
    len_d   = len_q;
    drop_d  = drop_o;
`ifdef PATTERN_MISR_GOLDEN_CMP_EN
    pass_d  = pass_o;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          sig_d   = SEED;
          cnt_d   = '0;
          len_d   = win_len_i;
          drop_d  = 1'b0;
`ifdef PATTERN_MISR_GOLDEN_CMP_EN
          pass_d  = 1'b0;
`endif
          state_d = (win_len_i == '0) ? DONE : RUN;
        end
        // A vector seen in IDLE is never absorbed, even alongside a start.
        if (resp_valid_i) drop_d = 1'b1;
      end
      RUN: begin
        if (resp_valid_i) begin
          sig_d = misr_step(sig_o, resp_i);
          cnt_d = vec_cnt_o + CNT_W'(1);
          if (vec_cnt_o == len_q - CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (sig_ack_i) state_d = IDLE;
        if (resp_valid_i) drop_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
`ifdef PATTERN_MISR_GOLDEN_CMP_EN
    // Compare on the DONE entry edge only; the result then holds.
    if (state_q != DONE && state_d == DONE) pass_d = (sig_d == golden_i);
`endif
  end

  // Registered datapath and status outputs.
  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      sig_o       <= SEED;
      vec_cnt_o   <= '0;
      len_q       <= '0;
      drop_o      <= 1'b0;
      busy_o      <= 1'b0;
      sig_valid_o <= 1'b0;
`ifdef PATTERN_MISR_GOLDEN_CMP_EN
      pass_o      <= 1'b0;
`endif
    end else begin
      sig_o       <= sig_d;
      vec_cnt_o   <= cnt_d;
      len_q       <= len_d;
      drop_o      <= drop_d;
      busy_o      <= (state_d == RUN);
      sig_valid_o <= (state_d == DONE);
`ifdef PATTERN_MISR_GOLDEN_CMP_EN
      pass_o      <= pass_d;
`endif
    end
  end

endmodule

// File: doc/pattern_response_misr.md
Name: pattern_response_misr

Overview:
- Downstream capture stage for the merged sequential/combinational pattern netlists.
- Samples the pattern's output vector once per valid cycle and compacts a window of vectors into a multiple-input signature register (MISR).
- Presents the final signature through a valid/ack handshake to the benchmark harness.
- Gives one signature per test window for equivalence checking between grammar-generated netlist variants.

Parameters:
- RESP_W, 13, width of the response vector taken from the pattern outputs.
- SIG_W, 16, signature width; must be >= RESP_W.
- CNT_W, 8, width of the window-length and vector counters.
- POLY, 16'h8016, MISR feedback polynomial taps, SIG_W bits.
- SEED, 16'h0000, signature value loaded at reset and on start.

Ports:
- blif_clk_net  in  1  sole clock, rising edge.
- blif_reset_net  in  1  asynchronous reset, active-high.
- start_i  in  1  request a new compaction window; level-sampled.
- win_len_i  in  CNT_W  number of vectors in the window; latched when start is accepted.
- resp_valid_i  in  1  resp_i is valid this cycle.
- resp_i  in  RESP_W  pattern output vector.
- sig_ack_i  in  1  harness has consumed the signature.
- busy_o  out  1  high in RUN.
- sig_valid_o  out  1  high in DONE.
- sig_o  out  SIG_W  current signature register.
- vec_cnt_o  out  CNT_W  vectors absorbed in the current window.
- drop_o  out  1  sticky flag: a valid vector arrived outside RUN.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state IDLE;
  - sig_o = SEED;
  - vec_cnt_o = 0;
  - busy_o = 0, sig_valid_o = 0, drop_o = 0;
  - latched length = 0.
- FSM states are IDLE, RUN and DONE.
- IDLE, when start_i = 1:
  - load sig = SEED, vec_cnt = 0, len = win_len_i;
  - clear drop_o;
  - if win_len_i = 0, go directly to DONE with sig = SEED; otherwise go to RUN.
- RUN, on each cycle with resp_valid_i = 1:
  - sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extend(resp_i);
  - vec_cnt <= vec_cnt + 1.
- RUN, cycles with resp_valid_i = 0: hold sig and vec_cnt.
- RUN exit: when a valid vector arrives with vec_cnt = len-1, go to DONE on the same edge. The final signature and sig_valid_o = 1 are visible the cycle after the last valid, so latency is 1 cycle.
- DONE:
  - sig_o and vec_cnt_o hold;
  - sig_valid_o stays high until sig_ack_i = 1, then go to IDLE;
  - sig_o keeps its value in IDLE until the next start.
- start_i is ignored in RUN and in DONE.
- ack and start in the same DONE cycle: ack wins and the FSM goes to IDLE. start must be reasserted in IDLE.
- sig_ack_i outside DONE: no effect.
- resp_valid_i = 1 in IDLE or DONE:
  - vector discarded, sig unchanged;
  - drop_o <= 1, sticky until the next accepted start.
- Counter arithmetic: vec_cnt never wraps. The maximum window is 2^CNT_W - 1 vectors.
- Reset asserted mid-RUN: window abandoned, all state returns to reset values immediately, no partial signature flagged valid.
- Registered outputs: all outputs are registered, with no combinational path from inputs to outputs.

Optional Feature:
- Macro: PATTERN_MISR_GOLDEN_CMP_EN.
- Defined:
  - adds input golden_i (SIG_W) and output pass_o (1);
  - pass_o is registered on the DONE entry edge as (next sig == golden_i);
  - pass_o holds through DONE and IDLE;
  - pass_o resets to 0 and clears on an accepted start.
- Undefined: neither port nor any compare logic exists, and the block behaves exactly as described above.

Test Plan:
- Reset, then deassert: sig_o = 16'h0000, vec_cnt_o = 0, busy_o = 0, sig_valid_o = 0, drop_o = 0.
- start with win_len = 2; resp 13'h0001 then 13'h0000 on consecutive valid cycles -> cycle after the 2nd valid: sig_valid_o = 1, sig_o = 16'h0002, vec_cnt_o = 2. Hold ack low 3 cycles -> all outputs stable. Ack -> IDLE next cycle.
- Feedback check: win_len = 16, resp 13'h0001 then 15 zero vectors -> sig_o = 16'h8000. Then win_len = 17 with the same vectors plus one more zero -> sig_o = 16'h8016.
- Gaps and win_len = 0: win_len = 3 with resp_valid toggling 1,0,0,1,0,1 -> DONE only after the 3rd valid, busy_o high throughout. Separately, win_len = 0 -> sig_valid_o = 1 one cycle after start, sig_o = SEED.
- Drops and collisions:
  - resp_valid_i in IDLE -> drop_o = 1, sig_o unchanged; drop_o clears on the next start.
  - Start and ack in the same DONE cycle -> IDLE, no new window, busy_o = 0.
  - Assert reset mid-RUN after 2 of 5 vectors -> sig_o = SEED and vec_cnt_o = 0 asynchronously.
- With PATTERN_MISR_GOLDEN_CMP_EN defined: the win_len = 2 case above with golden_i = 16'h0002 -> pass_o = 1. With golden_i = 16'h0003 -> pass_o = 0.
